// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART: FSM state encoding and bit-period calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    STOP_WAIT
  } uartState_e;

  // Clocks per bit; DEBUG builds use a very short period so simulations stay fast.
  function automatic int cpb(input int clkHz, input int baud, input bit debug);
    return debug ? 5 : clkHz / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: two-flop synchroniser on the serial input plus a mid-bit sampling 8N1 receive FSM.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CPB = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd_i,
  output logic [7:0] rxData_o,
  output logic       dataValid_o
);

  localparam int CNT_W   = $clog2(CPB) + 1;
  localparam int HALF_M1 = (CPB / 2 > 0) ? (CPB / 2 - 1) : 0;
  localparam int CPB_M1  = CPB - 1;

  logic             sync1_q, sync2_q;
  logic             rxs;
  uartState_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rxData_q, rxData_d;
  logic             dataValid_q, dataValid_d;

  assign rxs = sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitIdx_q    <= '0;
      shift_q     <= '0;
      rxData_q    <= '0;
      dataValid_q <= 1'b0;
    end else begin
      sync1_q     <= rxd_i;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitIdx_q    <= bitIdx_d;
      shift_q     <= shift_d;
      rxData_q    <= rxData_d;
      dataValid_q <= dataValid_d;
    end
  end

  // START samples half a bit in to reject glitches; later samples land mid-bit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bitIdx_d    = bitIdx_q;
    shift_d     = shift_q;
    rxData_d    = rxData_q;
    dataValid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        bitIdx_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_W'(HALF_M1)) begin
          cnt_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_W'(CPB_M1)) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          if (bitIdx_q == 3'd7) state_d = STOP;
          else bitIdx_d = bitIdx_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_W'(CPB_M1)) begin
          cnt_d = '0;
          if (rxs) begin
            rxData_d    = shift_q;
            dataValid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = STOP_WAIT;
          end
        end
      end
      STOP_WAIT: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rxData_o    = rxData_q;
  assign dataValid_o = dataValid_q;

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART top: receiver sub-module plus an inline transmitter sharing one bit period.
module uart
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200,
  parameter bit DEBUG  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] rxData,
  output logic       dataValid,
  input  logic [7:0] txData,
  input  logic       txSend,
  output logic       txReady
);

  localparam int CPB    = cpb(CLK_HZ, BAUD, DEBUG);
  localparam int CNT_W  = $clog2(CPB) + 1;
  localparam int CPB_M1 = CPB - 1;

  uart_rx #(
    .CPB(CPB)
  ) uRx (
    .clk        (clk),
    .reset      (reset),
    .rxd_i      (rxd),
    .rxData_o   (rxData),
    .dataValid_o(dataValid)
  );

  uartState_e       txState_q, txState_d;
  logic [CNT_W-1:0] txCnt_q, txCnt_d;
  logic [2:0]       txBitIdx_q, txBitIdx_d;
  logic [7:0]       txShift_q, txShift_d;
  logic             txd_q, txd_d;
  logic             txReady_q, txReady_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txState_q  <= IDLE;
      txCnt_q    <= '0;
      txBitIdx_q <= '0;
      txShift_q  <= '0;
      txd_q      <= 1'b1;
      txReady_q  <= 1'b1;
    end else begin
      txState_q  <= txState_d;
      txCnt_q    <= txCnt_d;
      txBitIdx_q <= txBitIdx_d;
      txShift_q  <= txShift_d;
      txd_q      <= txd_d;
      txReady_q  <= txReady_d;
    end
  end

  // txd is registered, so each bit's value is chosen the cycle its predecessor ends.
  always_comb begin
    txState_d  = txState_q;
    txCnt_d    = txCnt_q + CNT_W'(1);
    txBitIdx_d = txBitIdx_q;
    txShift_d  = txShift_q;
    txd_d      = txd_q;
    txReady_d  = txReady_q;
    case (txState_q)
      IDLE: begin
        txCnt_d = '0;
        if (txSend) begin
          txShift_d = txData;
          txd_d     = 1'b0;
          txReady_d = 1'b0;
          txState_d = START;
        end
      end
      START: begin
        if (txCnt_q == CNT_W'(CPB_M1)) begin
          txCnt_d    = '0;
          txBitIdx_d = '0;
          txd_d      = txShift_q[0];
          txState_d  = DATA;
        end
      end
      DATA: begin
        if (txCnt_q == CNT_W'(CPB_M1)) begin
          txCnt_d = '0;
          if (txBitIdx_q == 3'd7) begin
            txd_d     = 1'b1;
            txState_d = STOP;
          end else begin
            txShift_d  = txShift_q >> 1;
            txd_d      = txShift_q[1];
            txBitIdx_d = txBitIdx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (txCnt_q == CNT_W'(CPB_M1)) begin
          txCnt_d   = '0;
          txReady_d = 1'b1;
          txState_d = IDLE;
        end
      end
      default: begin
        txd_d     = 1'b1;
        txReady_d = 1'b1;
        txState_d = IDLE;
      end
    endcase
  end

  assign txd     = txd_q;
  assign txReady = txReady_q;

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart (DEBUG build): random frames on both directions against a frame-level model.
module tb_uart;

  localparam int CPB = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxd = 1'b1;
  logic       txd;
  logic [7:0] rxData;
  logic       dataValid;
  logic [7:0] txData = 8'h00;
  logic       txSend = 1'b0;
  logic       txReady;

  int checkCount = 0;
  int passCount  = 0;

  int cycle = 0;
  int pulseCount = 0;
  int highCycles = 0;
  int lastPulseCycle = 0;
  int rxStartCycle = 0;
  bit prevValid = 1'b0;
  logic [7:0] expectedRx = 8'h00;

  uart #(
    .CLK_HZ(100_000_000),
    .BAUD  (115200),
    .DEBUG (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rxd      (rxd),
    .txd      (txd),
    .rxData   (rxData),
    .dataValid(dataValid),
    .txData   (txData),
    .txSend   (txSend),
    .txReady  (txReady)
  );

  always #5 clk = ~clk;

  // Counts dataValid pulses and their widths just after each rising edge.
  always @(posedge clk) begin
    #1;
    cycle++;
    if (dataValid === 1'b1) begin
      highCycles++;
      if (!prevValid) begin
        pulseCount++;
        lastPulseCycle = cycle;
      end
    end
    prevValid = (dataValid === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Drives one serial frame on rxd: start 0, data LSB first, then the given stop level.
  task automatic rxFrame(input logic [7:0] b, input bit stopBit);
    logic [9:0] frame;
    frame = {stopBit, b, 1'b0};
    rxStartCycle = cycle;
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  // Sends one byte and checks the line bit by bit mid-period, plus busy duration.
  task automatic txFrame(input logic [7:0] b, input bit injectBusy);
    logic [9:0] frame;
    int lowReady;
    int lowTxd;
    int zeros;
    bit done;
    frame = {1'b1, b, 1'b0};
    lowReady = 0;
    lowTxd = 0;
    zeros = 0;
    done = 1'b0;
    for (int i = 0; i < 10; i++) if (!frame[i]) zeros++;
    checkOutput("tx_ready_before", {31'b0, txReady}, 32'd1);
    txData = b;
    txSend = 1'b1;
    @(negedge clk);
    txSend = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      if (txReady === 1'b1) begin
        done = 1'b1;
      end else begin
        lowReady++;
        if (txd === 1'b0) lowTxd++;
        if ((k % CPB) == (CPB / 2) && (k / CPB) < 10)
          checkOutput($sformatf("tx_bit%0d_of_%02h", k / CPB, b), {31'b0, txd},
                      {31'b0, frame[k/CPB]});
        if (injectBusy && k == 20) begin
          txData = 8'hFF;
          txSend = 1'b1;
        end else begin
          txSend = 1'b0;
        end
        @(negedge clk);
      end
    end
    txSend = 1'b0;
    checkOutput("tx_done", {31'b0, done}, 32'd1);
    checkOutput("tx_ready_low_cycles", lowReady, 10 * CPB);
    checkOutput("tx_txd_low_cycles", lowTxd, zeros * CPB);
    checkOutput("tx_idle_high", {31'b0, txd}, 32'd1);
  endtask

  // Runs an RX frame and/or a TX frame concurrently, then checks the receive side against the model.
  task automatic applyStimulus(input string name, input bit doRx, input logic [7:0] rxByte,
                               input bit rxStop, input bit doTx, input logic [7:0] txByte,
                               input bit injectBusy);
    int p0;
    int h0;
    int expPulses;
    p0 = pulseCount;
    h0 = highCycles;
    fork
      if (doRx) rxFrame(rxByte, rxStop);
      if (doTx) txFrame(txByte, injectBusy);
    join
    repeat (3 * CPB) @(negedge clk);
    expPulses = (doRx && rxStop) ? 1 : 0;
    if (expPulses == 1) expectedRx = rxByte;
    checkOutput({name, "_pulses"}, pulseCount - p0, expPulses);
    checkOutput({name, "_valid_cycles"}, highCycles - h0, expPulses);
    checkOutput({name, "_rxdata"}, {24'b0, rxData}, {24'b0, expectedRx});
    if (expPulses == 1) begin
      int lat;
      lat = lastPulseCycle - rxStartCycle;
      checkOutput({name, "_latency_ok"}, {31'b0, (lat >= CPB / 2 + 9 * CPB + 2 &&
                  lat <= CPB / 2 + 9 * CPB + 3)}, 32'd1);
    end
  endtask

  initial begin
    int p0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_txd", {31'b0, txd}, 32'd1);
    checkOutput("reset_txready", {31'b0, txReady}, 32'd1);
    checkOutput("reset_datavalid", {31'b0, dataValid}, 32'd0);
    checkOutput("reset_rxdata", {24'b0, rxData}, 32'h00);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    applyStimulus("rx_a5", 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus("rx_break", 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus("rx_3c", 1'b1, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b0);

    p0 = pulseCount;
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    checkOutput("glitch_pulses", pulseCount - p0, 0);
    checkOutput("glitch_rxdata", {24'b0, rxData}, {24'b0, expectedRx});
    applyStimulus("rx_after_glitch", 1'b1, 8'($urandom), 1'b1, 1'b0, 8'h00, 1'b0);

    applyStimulus("tx_00", 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);
    applyStimulus("tx_busy", 1'b0, 8'h00, 1'b1, 1'b1, 8'($urandom), 1'b1);
    applyStimulus("tx_81", 1'b0, 8'h00, 1'b1, 1'b1, 8'h81, 1'b0);

    for (int n = 0; n < 8; n++) begin
      applyStimulus($sformatf("duplex%0d", n), 1'b1, 8'($urandom),
                    ($urandom_range(0, 3) != 0), 1'b1, 8'($urandom), 1'b0);
    end

    p0 = pulseCount;
    txData = 8'h00;
    txSend = 1'b1;
    rxd = 1'b0;
    @(negedge clk);
    txSend = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    checkOutput("midframe_txready", {31'b0, txReady}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    expectedRx = 8'h00;
    checkOutput("midreset_txd", {31'b0, txd}, 32'd1);
    checkOutput("midreset_txready", {31'b0, txReady}, 32'd1);
    checkOutput("midreset_datavalid", {31'b0, dataValid}, 32'd0);
    checkOutput("midreset_rxdata", {24'b0, rxData}, 32'h00);
    rxd = 1'b1;
    reset = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    checkOutput("midreset_pulses", pulseCount - p0, 0);
    checkOutput("midreset_txd_idle", {31'b0, txd}, 32'd1);
    applyStimulus("after_reset", 1'b1, 8'($urandom), 1'b1, 1'b1, 8'($urandom), 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
